// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready flow control and a 2-entry skid buffer.
// Head entry drives MEM and the forwarding unit; control outputs are bubble-gated.
module ex_mem_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 8,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ALU_data,
    input  logic [XLEN-1:0] rd_data,
    input  logic [PC_W-1:0] branch_target,
    input  logic            zero,
    input  logic [RA_W-1:0] Rd,
    input  logic            MemtoReg,
    input  logic            regwrite,
    input  logic            branch,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_data_out,
    output logic [XLEN-1:0] rd_data_out,
    output logic [PC_W-1:0] branch_target_out,
    output logic            zero_out,
    output logic [RA_W-1:0] EX_MEM_rd,
    output logic            MemtoReg_out,
    output logic            regwrite_out,
    output logic            branch_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic            pc_src,
    output logic [1:0]      occupancy
);

    localparam int PW = 2*XLEN + PC_W + 1 + RA_W + 5;

    logic          h_valid;
    logic          s_valid;
    logic [PW-1:0] h_data;
    logic [PW-1:0] s_data;
    logic [PW-1:0] in_data;
    logic          accept;
    logic          pop;
    logic [RA_W-1:0] rd_head;
    logic [4:0]      ctrl_head;

    assign in_data = {ALU_data, rd_data, branch_target, zero, Rd,
                      MemtoReg, regwrite, branch, MemRead, MemWrite};

    // in_ready depends only on registered state, never on out_ready
    assign in_ready  = !s_valid;
    assign out_valid = h_valid;
    assign accept    = in_valid & in_ready;
    assign pop       = h_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
            h_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            h_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!h_valid || pop) begin
            if (s_valid) begin
                h_data  <= s_data;
                h_valid <= 1'b1;
                s_valid <= accept;
                if (accept)
                    s_data <= in_data;
            end else begin
                h_valid <= accept;
                if (accept)
                    h_data <= in_data;
            end
        end else if (accept) begin
            s_data  <= in_data;
            s_valid <= 1'b1;
        end
    end

    assign {ALU_data_out, rd_data_out, branch_target_out, zero_out, rd_head, ctrl_head} = h_data;

    // Bubbles present x0 and no control so forwarding and MEM ignore them
    assign EX_MEM_rd = h_valid ? rd_head : '0;
    assign {MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out} =
           ctrl_head & {5{h_valid}};
    assign pc_src    = h_valid & ctrl_head[2] & zero_out;
    assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver queues accepted items, the monitor checks every cycle.
module tb_ex_mem_stage;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] rdd;
        logic [7:0]  bt;
        logic        z;
        logic [4:0]  rd;
        logic [4:0]  ctrl;   // {MemtoReg, regwrite, branch, MemRead, MemWrite}
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ALU_data = '0;
    logic [63:0] rd_data = '0;
    logic [7:0]  branch_target = '0;
    logic        zero = 1'b0;
    logic [4:0]  Rd = '0;
    logic        MemtoReg = 1'b0, regwrite = 1'b0, branch = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] ALU_data_out, rd_data_out;
    logic [7:0]  branch_target_out;
    logic        zero_out;
    logic [4:0]  EX_MEM_rd;
    logic        MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out;
    logic        pc_src;
    logic [1:0]  occupancy;

    int tests = 0;
    int errors = 0;
    item_t exp_q[$];
    bit mdl_ready = 1'b1;

    ex_mem_stage #(.XLEN(64), .PC_W(8), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_data(ALU_data), .rd_data(rd_data), .branch_target(branch_target),
        .zero(zero), .Rd(Rd),
        .MemtoReg(MemtoReg), .regwrite(regwrite), .branch(branch),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_data_out(ALU_data_out), .rd_data_out(rd_data_out),
        .branch_target_out(branch_target_out), .zero_out(zero_out),
        .EX_MEM_rd(EX_MEM_rd),
        .MemtoReg_out(MemtoReg_out), .regwrite_out(regwrite_out), .branch_out(branch_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .pc_src(pc_src), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare against the FIFO model, then retire the head on a handshake
    always @(negedge clk) begin
        if (!reset) begin
            item_t h;
            mdl_ready = exp_q.size() < 2;
            chk("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
            chk("in_ready", {63'd0, in_ready}, {63'd0, mdl_ready});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                chk("alu_out", ALU_data_out, h.alu);
                chk("rd_data_out", rd_data_out, h.rdd);
                chk("branch_target_out", {56'd0, branch_target_out}, {56'd0, h.bt});
                chk("zero_out", {63'd0, zero_out}, {63'd0, h.z});
                chk("ex_mem_rd", {59'd0, EX_MEM_rd}, {59'd0, h.rd});
                chk("ctrl_out", {59'd0, MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out},
                    {59'd0, h.ctrl});
                chk("pc_src", {63'd0, pc_src}, {63'd0, h.ctrl[2] & h.z});
            end else begin
                chk("bubble_ctrl", {59'd0, MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out}, 64'd0);
                chk("bubble_rd", {59'd0, EX_MEM_rd}, 64'd0);
                chk("bubble_pc_src", {63'd0, pc_src}, 64'd0);
            end
            if (flush)
                exp_q.delete();
            else if (exp_q.size() > 0 && out_ready)
                void'(exp_q.pop_front());
        end
    end

    function automatic item_t mk(input logic [63:0] alu, input logic [4:0] rd,
                                 input logic [4:0] ctrl, input logic z, input logic [7:0] bt);
        item_t it;
        it.alu = alu; it.rdd = {$urandom, $urandom}; it.bt = bt; it.z = z; it.rd = rd; it.ctrl = ctrl;
        return it;
    endfunction

    function automatic item_t rnd_item();
        return mk({$urandom, $urandom}, 5'($urandom), 5'($urandom), 1'($urandom), 8'($urandom));
    endfunction

    // One clock: drive inputs, then at the edge record an accept into the scoreboard
    task automatic cycle(input bit v, input item_t it, input bit ordy, input bit fl, output bit acc);
        in_valid = v; ALU_data = it.alu; rd_data = it.rdd; branch_target = it.bt;
        zero = it.z; Rd = it.rd;
        {MemtoReg, regwrite, branch, MemRead, MemWrite} = it.ctrl;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        acc = v && !fl && mdl_ready;
        if (acc) exp_q.push_back(it);
        #1;
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        cycle(1'b0, rnd_item(), ordy, 1'b0, acc);
    endtask

    task automatic send(input item_t it, input bit ordy);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 50) begin
            cycle(1'b1, it, ordy, 1'b0, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit acc;
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        #11 reset = 1'b0;
        @(posedge clk); #1;

        // Reset asserted between edges while an item is held
        cycle(1'b1, mk(64'h1234, 5'd3, 5'b01000, 1'b0, 8'h00), 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midreset_alu", ALU_data_out, 64'd0);
        chk("midreset_regwrite", {63'd0, regwrite_out}, 64'd0);
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_occupancy", {62'd0, occupancy}, 64'd0);
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        #1 reset = 1'b0;
        exp_q.delete();
        mdl_ready = 1'b1;
        idle(1'b1);

        // Streaming
        for (int i = 1; i <= 3; i++)
            send(mk(64'(i), 5'(i + 4), 5'b01000, 1'b0, 8'h10), 1'b1);
        idle(1'b1);

        // Stall into the skid buffer, C held off, then drain
        send(mk(64'hA, 5'd1, 5'b01000, 1'b0, 8'h0), 1'b0);
        send(mk(64'hB, 5'd2, 5'b00001, 1'b0, 8'h0), 1'b0);
        cycle(1'b1, mk(64'hC, 5'd3, 5'b10010, 1'b0, 8'h0), 1'b0, 1'b0, acc);
        cycle(1'b1, mk(64'hC, 5'd3, 5'b10010, 1'b0, 8'h0), 1'b0, 1'b0, acc);
        send(mk(64'hC, 5'd3, 5'b10010, 1'b0, 8'h0), 1'b1);
        repeat (3) idle(1'b1);

        // Flush while full with a simultaneous input
        send(mk(64'h11, 5'd4, 5'b01000, 1'b0, 8'h0), 1'b0);
        send(mk(64'h22, 5'd5, 5'b01000, 1'b0, 8'h0), 1'b0);
        cycle(1'b1, mk(64'hD, 5'd6, 5'b01000, 1'b0, 8'h0), 1'b1, 1'b1, acc);
        repeat (2) idle(1'b1);

        // Branch decision taken / not taken
        send(mk(64'h0, 5'd0, 5'b00100, 1'b1, 8'h40), 1'b1);
        send(mk(64'h5, 5'd0, 5'b00100, 1'b0, 8'h40), 1'b1);
        idle(1'b1);

        // Bubble after a register-writing item
        send(mk(64'h99, 5'd9, 5'b01001, 1'b0, 8'h0), 1'b1);
        repeat (2) idle(1'b1);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), rnd_item(), 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0), acc);
        end
        repeat (4) idle(1'b1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
